// File: rtl/keypad_scan_fifo_pkg.sv
// Shared types, defaults and the key-code helper for the keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS        = 4;
    localparam int KP_COLS        = 4;
    localparam int KP_SCAN_CYCLES = 8;
    localparam int KP_DEBOUNCE    = 16;
    localparam int KP_DEPTH       = 4;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_e;

    function automatic int unsigned code_of(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// Valid/ready key-code channel from the keypad scanner to its consumer.
interface keypad_scan_fifo_if
    import keypad_pkg::*;
#(
    parameter int CW = $clog2(KP_ROWS * KP_COLS)
) ();

    logic [CW-1:0] key_code;
    logic          key_valid;
    logic          key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);

endinterface

// File: rtl/keypad_scan_fifo_key_fifo.sv
// First-word-fall-through key FIFO; head shows the last popped code while empty.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = KP_DEPTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign dout  = empty ? last_q : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        ovf_d    = push && full && !do_pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column drive, row debounce, one push per press into a key FIFO.
// Define KEYPAD_REPEAT_EN to re-push a held key after a delay and then at a fixed rate.
module keypad_scan_fifo
    import keypad_pkg::*;
#(
    parameter int ROWS        = KP_ROWS,
    parameter int COLS        = KP_COLS,
    parameter int SCAN_CYCLES = KP_SCAN_CYCLES,
    parameter int DEBOUNCE    = KP_DEBOUNCE,
    parameter int DEPTH       = KP_DEPTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    output logic [COLS-1:0]        col_n,
    input  logic [ROWS-1:0]        row_n,
    keypad_scan_fifo_if.master     kbus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int CW  = $clog2(ROWS * COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);
    localparam int SW  = $clog2(SCAN_CYCLES);
    localparam int DW  = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS - 1);
    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [$clog2(DEPTH):0] FULL_CNT = ($clog2(DEPTH) + 1)'(DEPTH);

    kp_state_e        state_q, state_d;
    logic [ROWS-1:0]  row_s1_q, row_s2_q;
    logic [SW-1:0]    slot_q, slot_d;
    logic [CLW-1:0]   col_q, col_d, col_next;
    logic [DW-1:0]    deb_q, deb_d;
    logic [RW-1:0]    row_idx_q, row_idx_d, low_row;
    logic [CW-1:0]    code_q, code_d;
    logic [CW-1:0]    fifo_dout;
    logic             fifo_empty, fifo_full;
    logic             any_low, latched_low, slot_end, push;

`ifdef KEYPAD_REPEAT_EN
    localparam int REPEAT_DELAY = 8 * DEBOUNCE;
    localparam int REPEAT_RATE  = 2 * DEBOUNCE;
    localparam int RPW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPW-1:0] RPT_DELAY_LAST = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RPT_RATE_LAST  = RPW'(REPEAT_RATE - 1);
    logic [RPW-1:0] rpt_q, rpt_d;
    logic           first_q, first_d;
`endif

    assign slot_end    = (slot_q == SLOT_LAST);
    assign slot_d      = slot_end ? '0 : slot_q + 1'b1;
    assign col_next    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    assign col_n       = ~(COLS'(1) << col_q);
    assign latched_low = ~row_s2_q[row_idx_q];

    // Iterating downward leaves the lowest-numbered active row selected.
    always_comb begin
        any_low = 1'b0;
        low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                any_low = 1'b1;
                low_row = RW'(r);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        deb_d     = deb_q;
        row_idx_d = row_idx_q;
        code_d    = code_q;
        push      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d     = rpt_q;
        first_d   = first_q;
`endif
        if (slot_end) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_idx_d = low_row;
                        code_d    = CW'(code_of(32'(low_row), 32'(col_q), COLS));
                        deb_d     = '0;
                        state_d   = DEB_PRESS;
                    end else begin
                        col_d = col_next;
                    end
                end
                DEB_PRESS: begin
                    if (!latched_low) begin
                        deb_d   = '0;
                        state_d = SCAN;
                    end else if (deb_q == DEB_LAST) begin
                        push    = 1'b1;
                        deb_d   = '0;
                        state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                        rpt_d   = '0;
                        first_d = 1'b1;
`endif
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!latched_low) begin
                        deb_d   = DW'(1);
                        state_d = DEB_REL;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // First repeat waits the long delay, later ones the short rate.
                    else if (rpt_q == (first_q ? RPT_DELAY_LAST : RPT_RATE_LAST)) begin
                        push    = 1'b1;
                        rpt_d   = '0;
                        first_d = 1'b0;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
`endif
                end
                DEB_REL: begin
                    if (latched_low) begin
                        deb_d   = '0;
                        state_d = HELD;
                    end else if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        col_d   = col_next;
                        state_d = SCAN;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= SCAN;
            row_s1_q <= '1;
            row_s2_q <= '1;
            slot_q   <= '0;
            col_q    <= '0;
            deb_q    <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q    <= '0;
            first_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
            slot_q   <= slot_d;
            col_q    <= col_d;
            deb_q    <= deb_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q    <= rpt_d;
            first_q  <= first_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        row_idx_q <= row_idx_d;
        code_q    <= code_d;
    end

    key_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (code_q),
        .pop    (kbus.key_ready),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count),
        .ovf    (overflow)
    );

    assign kbus.key_code  = fifo_dout;
    assign kbus.key_valid = !fifo_empty;

    a_full_count : assert property (@(posedge clk) disable iff (!resetn)
        fifo_full |-> (fifo_count == FULL_CNT));

endmodule
